// File: rtl/izhikevich_state_update_if.sv
// Bundles the ports of the state-update stage: the input handshake, the dv-stage loop and the result handshake.
// Latency: none, wiring only.
// Backpressure: carries in_ready and out_ready; the interface itself holds no state.
interface izhikevich_state_update_if #(
  parameter int N     = 16,
  parameter int CNT_W = 16
);
  // upstream request
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     i_in;
  logic [N-1:0]     step_in;
  // loop to and from the combinational dv stage
  logic [N-1:0]     v_out;
  logic [N-1:0]     w_out;
  logic [N-1:0]     i_out;
  logic [N-1:0]     step_out;
  logic [N-1:0]     dv_in;
  // downstream result
  logic             out_valid;
  logic             out_ready;
  logic             spike;
  logic [CNT_W-1:0] spike_count;

  // the state-update block itself
  modport slave (
    input  in_valid, i_in, step_in, dv_in, out_ready,
    output in_ready, v_out, w_out, i_out, step_out, out_valid, spike, spike_count
  );

  // the surrounding fabric: source, dv stage and sink together
  modport master (
    output in_valid, i_in, step_in, dv_in, out_ready,
    input  in_ready, v_out, w_out, i_out, step_out, out_valid, spike, spike_count
  );
endinterface

// File: rtl/izhikevich_state_update.sv
// Izhikevich state-update stage: holds v/w, adds dv from the dv stage, computes dw, thresholds and counts spikes.
// Latency: accept at edge T, result valid from T+3; at most one update every 4 cycles.
// Backpressure: result held in OUT until out_ready; in_ready is low outside IDLE and in_valid there is dropped.
module izhikevich_state_update #(
  parameter int                 N      = 16,
  parameter int                 Q      = 8,
  parameter int                 CNT_W  = 16,
  parameter logic signed [N-1:0] V_TH   = 16'h004D,
  parameter logic signed [N-1:0] C_RST  = 16'hFF5A,
  parameter logic signed [N-1:0] D_INC  = 16'h0014,
  parameter logic signed [N-1:0] A_COEF = 16'h0005,
  parameter logic signed [N-1:0] B_COEF = 16'h0033,
  parameter logic signed [N-1:0] W_INIT = 16'hFFDF
) (
  input logic                         clk,
  input logic                         reset,
  izhikevich_state_update_if.slave    bus
);

  localparam logic signed [N-1:0] MAX_V = {1'b0, {(N-1){1'b1}}};
  localparam logic signed [N-1:0] MIN_V = {1'b1, {(N-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, EVAL, INTEG, OUT} state_t;

  // Saturating add: one guard bit catches overflow, clamp to the rail of the true sign.
  function automatic logic signed [N-1:0] sat_add(input logic signed [N-1:0] a,
                                                  input logic signed [N-1:0] b);
    logic signed [N:0] s;
    s = {a[N-1], a} + {b[N-1], b};
    if (s[N] != s[N-1]) sat_add = s[N] ? MIN_V : MAX_V;
    else                sat_add = s[N-1:0];
  endfunction

  // Saturating subtract, same guard-bit scheme as sat_add.
  function automatic logic signed [N-1:0] sat_sub(input logic signed [N-1:0] a,
                                                  input logic signed [N-1:0] b);
    logic signed [N:0] s;
    s = {a[N-1], a} - {b[N-1], b};
    if (s[N] != s[N-1]) sat_sub = s[N] ? MIN_V : MAX_V;
    else                sat_sub = s[N-1:0];
  endfunction

  // Fixed-point multiply: full product, arithmetic shift (floor), then clamp.
  // The result fits only if all bits above the kept sign bit agree with it.
  function automatic logic signed [N-1:0] mult(input logic signed [N-1:0] a,
                                               input logic signed [N-1:0] b);
    logic signed [2*N-1:0] p;
    logic signed [2*N-1:0] sh;
    p  = $signed({{N{a[N-1]}}, a}) * $signed({{N{b[N-1]}}, b});
    sh = p >>> Q;
    if ((&sh[2*N-1:N-1]) || !(|sh[2*N-1:N-1])) mult = sh[N-1:0];
    else                                       mult = sh[2*N-1] ? MIN_V : MAX_V;
  endfunction

  state_t                 state_q, state_d;
  logic signed [N-1:0]    v_q, w_q, i_q, step_q, dv_q, dw_q;
  logic                   out_valid_q, spike_q;
  logic [CNT_W-1:0]       spike_count_q;

  // dw chain evaluated from the registered v/w and latched step
  logic signed [N-1:0]    bv, rec_drive, a_term, dw_c;
  // integration results
  logic signed [N-1:0]    v_n, w_n, w_spk;
  logic                   fire;

  assign bv        = mult(B_COEF, v_q);
  assign rec_drive = sat_sub(bv, w_q);
  assign a_term    = mult(A_COEF, rec_drive);
  assign dw_c      = mult(a_term, step_q);

  assign v_n   = sat_add(v_q, dv_q);
  assign w_n   = sat_add(w_q, dw_q);
  assign w_spk = sat_add(w_n, D_INC);
  assign fire  = (v_n >= V_TH);

  // State register; reset drops any in-flight update back to IDLE.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state: fixed three-cycle pipeline, then wait in OUT for the consumer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid)  state_d = EVAL;
      EVAL:    state_d = INTEG;
      INTEG:   state_d = OUT;
      OUT:     if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: latch inputs, capture dv/dw, integrate and threshold, then release the result.
  always_ff @(posedge clk) begin
    if (reset) begin
      v_q           <= C_RST;
      w_q           <= W_INIT;
      i_q           <= '0;
      step_q        <= '0;
      dv_q          <= '0;
      dw_q          <= '0;
      out_valid_q   <= 1'b0;
      spike_q       <= 1'b0;
      spike_count_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            i_q    <= bus.i_in;
            step_q <= bus.step_in;
          end
        end
        EVAL: begin
          dv_q <= bus.dv_in;
          dw_q <= dw_c;
        end
        INTEG: begin
          out_valid_q <= 1'b1;
          if (fire) begin
            v_q     <= C_RST;
            w_q     <= w_spk;
            spike_q <= 1'b1;
            if (spike_count_q != {CNT_W{1'b1}})
              spike_count_q <= spike_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
          end else begin
            v_q     <= v_n;
            w_q     <= w_n;
            spike_q <= 1'b0;
          end
        end
        OUT: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            spike_q     <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready    = (state_q == IDLE) && !reset;
  assign bus.v_out       = v_q;
  assign bus.w_out       = w_q;
  assign bus.i_out       = i_q;
  assign bus.step_out    = step_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.spike       = spike_q;
  assign bus.spike_count = spike_count_q;

endmodule
